// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and parity polarity constants.
`timescale 1ns/1ps
package uart_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the flops
// reset to RESET_VAL so an idle line does not look active after reset.
`timescale 1ns/1ps
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop recovery with a
// valid/ready holding register and single-cycle error pulses.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = PARITY_EVEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          PAR_INV   = (PARITY_ODD != 0);
    localparam logic          PAR_ON    = (PARITY_EN != 0);

    logic rxs;

    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 valid_d;
    logic                 fe_d, pe_d, ov_d;
    logic                 deliver, load;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_bad_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_bad_q  <= par_bad_d;
            rx_data    <= rx_data_d;
            rx_valid   <= valid_d;
            frame_err  <= fe_d;
            parity_err <= pe_d;
            overrun    <= ov_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        deliver   = 1'b0;
        fe_d      = 1'b0;
        pe_d      = 1'b0;

        if (os_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (rxs) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        // Line order is LSB first, so new bits enter at the top.
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = PAR_ON ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        par_bad_d = rxs ^ (^shreg_q) ^ PAR_INV;
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (!rxs) begin
                            fe_d    = 1'b1;
                            state_d = ST_BREAK;
                        end else if (par_bad_q) begin
                            pe_d    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxs) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A same-cycle accept frees the holding register for the new byte.
        load      = deliver && (!rx_valid || rx_ready);
        ov_d      = deliver && rx_valid && !rx_ready;
        rx_data_d = load ? shreg_q : rx_data;
        if (load) valid_d = 1'b1;
        else if (rx_ready) valid_d = 1'b0;
        else valid_d = rx_valid;
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame tests for uart_rx (8N1 and even-parity
// instances) against a frame-level outcome model.
`timescale 1ns/1ps
module tb_uart_rx;

    typedef enum int {R_GOOD, R_FRAME, R_PARITY} res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic os_tick = 1'b1;

    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       va, vb, fea, feb, pea, peb, ova, ovb, busy_a, busy_b;

    int total = 0;
    int bad = 0;

    int         nv[2] = '{0, 0};
    int         nfe[2] = '{0, 0};
    int         npe[2] = '{0, 0};
    int         nov[2] = '{0, 0};
    logic [7:0] last[2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .os_tick(os_tick), .rx(rx_a),
        .rx_data(data_a), .rx_valid(va), .rx_ready(ready_a),
        .frame_err(fea), .parity_err(pea), .overrun(ova), .busy(busy_a)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .reset(reset), .os_tick(os_tick), .rx(rx_b),
        .rx_data(data_b), .rx_valid(vb), .rx_ready(ready_b),
        .frame_err(feb), .parity_err(peb), .overrun(ovb), .busy(busy_b)
    );

    always @(negedge clk) begin
        if (va) begin nv[0]++; last[0] = data_a; end
        if (vb) begin nv[1]++; last[1] = data_b; end
        if (fea) nfe[0]++;
        if (feb) nfe[1]++;
        if (pea) npe[0]++;
        if (peb) npe[1]++;
        if (ova) nov[0]++;
        if (ovb) nov[1]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame outcome from the line contents alone: stop bit first, then parity.
    function automatic res_t model(input logic [7:0] d, input bit par_en, input bit odd,
                                   input logic pbit, input logic stop);
        int want;
        if (!stop) return R_FRAME;
        want = ($countones(d) + (odd ? 1 : 0)) % 2;
        if (par_en && (int'(pbit) != want)) return R_PARITY;
        return R_GOOD;
    endfunction

    task automatic drive_bit(input int dut, input logic v, input int n);
        if (dut == 0) rx_a = v; else rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int dut, input logic [7:0] d, input bit par_en,
                        input logic pbit, input logic stop);
        drive_bit(dut, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(dut, d[i], 16);
        if (par_en) drive_bit(dut, pbit, 16);
        drive_bit(dut, stop, 16);
    endtask

    task automatic frame_test(input int dut, input logic [7:0] d, input logic pbit,
                              input logic stop);
        int v0, f0, p0, o0;
        bit pe_on;
        res_t r;
        pe_on = (dut == 1);
        v0 = nv[dut]; f0 = nfe[dut]; p0 = npe[dut]; o0 = nov[dut];
        send(dut, d, pe_on, pbit, stop);
        chk("busy_after_stop", 32'(dut == 0 ? busy_a : busy_b), (stop ? 0 : 1));
        drive_bit(dut, 1'b1, 20);
        r = model(d, pe_on, 1'b0, pbit, stop);
        chk("valid_cycles", nv[dut] - v0, (r == R_GOOD) ? 1 : 0);
        chk("frame_err", nfe[dut] - f0, (r == R_FRAME) ? 1 : 0);
        chk("parity_err", npe[dut] - p0, (r == R_PARITY) ? 1 : 0);
        chk("overrun", nov[dut] - o0, 0);
        if (r == R_GOOD) chk("rx_data", 32'(last[dut]), 32'(d));
    endtask

    initial begin
        int v0, f0, o0;
        logic [7:0] d;
        logic pb, st;

        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {data_a, va, fea, pea, ova, busy_a}, 0);
        chk("reset_outputs_b", {data_b, vb, feb, peb, ovb, busy_b}, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        frame_test(0, 8'hA5, 1'b0, 1'b1);

        // Short low glitch: false start, no byte.
        v0 = nv[0]; f0 = nfe[0];
        drive_bit(0, 1'b0, 4);
        chk("glitch_busy", 32'(busy_a), 1);
        drive_bit(0, 1'b1, 20);
        chk("glitch_idle", 32'(busy_a), 0);
        chk("glitch_no_valid", nv[0] - v0, 0);
        chk("glitch_no_ferr", nfe[0] - f0, 0);

        // Bad stop bit followed by a long break.
        v0 = nv[0]; f0 = nfe[0];
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive_bit(0, 1'b0, 40 * 16);
        chk("break_busy", 32'(busy_a), 1);
        chk("break_ferr_once", nfe[0] - f0, 1);
        chk("break_no_valid", nv[0] - v0, 0);
        drive_bit(0, 1'b1, 32);
        chk("break_exit", 32'(busy_a), 0);
        frame_test(0, 8'h55, 1'b0, 1'b1);

        frame_test(1, 8'h07, 1'b1, 1'b1);
        frame_test(1, 8'h07, 1'b0, 1'b1);

        // Holding register full: second byte overruns, first is kept.
        ready_a = 1'b0;
        o0 = nov[0];
        send(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 4);
        chk("ovr_valid", 32'(va), 1);
        chk("ovr_data", 32'(data_a), 32'h11);
        chk("ovr_pulse", nov[0] - o0, 1);
        ready_a = 1'b1;
        @(negedge clk);
        chk("ovr_accept_clear", 32'(va), 0);
        drive_bit(0, 1'b1, 8);

        // Reset in the middle of data bit 4 of 0xFF.
        drive_bit(0, 1'b0, 16);
        drive_bit(0, 1'b1, 4 * 16 + 8);
        chk("pre_reset_busy", 32'(busy_a), 1);
        reset = 1'b0;
        rx_a = 1'b1;
        #1;
        chk("mid_reset_outputs", {data_a, va, fea, pea, ova, busy_a}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        frame_test(0, 8'h81, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            frame_test(0, d, 1'b0, st);
        end
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) != 0);
            frame_test(1, d, pb, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the team's baud/tick generation. Consumes a one-`clk`-wide strobe at OVERSAMPLE × baud and the asynchronous serial line `rx`. Recovers 8N1 frames (optional parity) and presents each byte on a valid/ready holding register. Reports framing, parity and overrun errors as single-cycle pulses.

## Interface
- DATA_BITS, 8, data bits per frame, LSB first (5..8)
- OVERSAMPLE, 16, os_tick strobes per bit period (even, ≥8)
- PARITY_EN, 0, 1 = one parity bit between data and stop
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)

- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- os_tick  in  1  oversample strobe, one clk wide, OVERSAMPLE × baud
- rx  in  1  serial line, asynchronous, idle high
- rx_data  out  DATA_BITS  received byte, stable while rx_valid=1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready
- frame_err  out  1  1-clk pulse: stop bit sampled 0, byte dropped
- parity_err  out  1  1-clk pulse: parity mismatch, byte dropped
- overrun  out  1  1-clk pulse: good byte arrived while holding register full and not accepted; new byte dropped
- busy  out  1  1 in any state except IDLE

## Operation
- `rx` passes a 2-FF synchronizer, reset value 1; all decisions use the synchronized value `rxs`.
- Counters: tick_cnt (clog2(OVERSAMPLE) bits) and bit_cnt (clog2(DATA_BITS) bits). Both advance only on os_tick.
- IDLE: on os_tick with rxs=0 → START, tick_cnt=0.
- START: on os_tick at tick_cnt=OVERSAMPLE/2-1 (mid start bit):
  - rxs=1 → false start, → IDLE.
  - rxs=0 → DATA, tick_cnt=0, bit_cnt=0.
- DATA: on os_tick at tick_cnt=OVERSAMPLE-1, shift rxs into the shift register MSB (LSB-first line order) and reset tick_cnt.
  - After bit DATA_BITS-1 → PARITY if PARITY_EN, else → STOP.
- PARITY: sample at tick_cnt=OVERSAMPLE-1 and compare against the XOR of the data bits (inverted if PARITY_ODD). Store the mismatch flag. → STOP.
- STOP: sample at tick_cnt=OVERSAMPLE-1.
  - rxs=0 → frame_err pulse, → BREAK.
  - rxs=1 with parity mismatch → parity_err pulse, → IDLE.
  - rxs=1, good frame → deliver, → IDLE.
  - Frame error takes priority over parity error.
- BREAK: wait for an os_tick with rxs=1 → IDLE. No start detection while in BREAK.
- Deliver, evaluated in the stop-sample cycle:
  - Holding register empty, or being accepted in the same cycle → load rx_data, rx_valid=1.
  - Otherwise → overrun pulse; old rx_data is kept.
- Handshake: rx_valid clears the cycle after rx_valid && rx_ready, unless a load happens in the same cycle, in which case it stays 1 with the new data.
- Reset (async, any state, mid-frame included): state=IDLE, counters=0, shift register=0, rx_data=0. All outputs 0, busy=0. Synchronizer stages =1.

## Timing
- Synchronizer latency: 2 clk from `rx` to `rxs`.
- Start detection: first os_tick seeing rxs=0; resolution 1/OVERSAMPLE bit.
- Data, parity and stop samples are taken OVERSAMPLE ticks apart, at nominal bit centers.
- rx_data/rx_valid and all error pulses assert 1 clk after the stop-sample os_tick cycle (registered).
- Return to IDLE from the stop sample, i.e. mid stop bit, so back-to-back frames are received.
- rx_valid is never combinationally dependent on rx_ready.
- os_tick gaps of any length are tolerated; state holds between strobes.

## Structure
- Shared package `uart_pkg`: state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), default OVERSAMPLE=16, DATA_BITS=8, and the parity polarity constants.
- Sub-module `uart_sync2`: 2-FF synchronizer with parameterized reset value, reusable for other async inputs.
- Everything else lives in a single FSM with its datapath.

## Test plan
All scenarios use os_tick=1 every clk, defaults unless noted.
- Send 0xA5, 8N1, rx_ready=1 → rx_data=0xA5, rx_valid high 1 clk, no error pulses, busy low after mid stop bit.
- 4-clk low glitch on rx in IDLE → START, then back to IDLE at tick 7, busy drops, no rx_valid.
- Send 0x3C with stop bit 0, then hold rx=0 for 40 bit times, then release and send 0x55 → frame_err single pulse, no 0x3C delivered, stays in BREAK until rx high, then rx_data=0x55.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 → delivered; send 0x07 with parity 0 → parity_err pulse, nothing delivered.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 held, overrun pulse at second stop; raise rx_ready → 0x11 accepted, rx_valid=0.
- Assert reset mid DATA bit 4 of 0xFF → all outputs 0 at once; after release, send 0x81 → delivered correctly.
